countdown_timer: RTL and testbench

Countdown timer for the home-controller board, directly upstream of the timer seven-segment display path. It loads a preset from the 4-bit `Timer` switches when `TimerSwitch` is turned on, then counts down once per second. It drives the 8-bit binary `BinTimerOut` that the display converts to BCD and blinks at zero, and it raises an alarm flag when the count expires.

---
 rtl/countdown_timer_if.sv | 31 +++
 rtl/countdown_timer.sv | 164 ++++++++++++++++
 tb/tb_countdown_timer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Signal bundle between the timer switches/preset and the countdown_timer core.
// The master side drives the controls; the slave side (the timer) drives the status outputs.
interface countdown_timer_if;
    logic [3:0] Timer;
    logic       TimerSwitch;
    logic       TimerClear;
    logic [7:0] BinTimerOut;
    logic       TimerRunning;
    logic       TimerDone;
    logic       TimerAlarm;

    modport master (
        output Timer,
        output TimerSwitch,
        output TimerClear,
        input  BinTimerOut,
        input  TimerRunning,
        input  TimerDone,
        input  TimerAlarm
    );

    modport slave (
        input  Timer,
        input  TimerSwitch,
        input  TimerClear,
        output BinTimerOut,
        output TimerRunning,
        output TimerDone,
        output TimerAlarm
    );
endinterface

// File: rtl/countdown_timer.sv
// Countdown timer: loads Timer*STEP seconds on a switch rising edge, counts down every CLK_HZ
// cycles. Defining COUNTDOWN_TIMER_ALARM_EN adds a timed alarm output after expiry.
module countdown_timer #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned STEP       = 10,
    parameter int unsigned ALARM_SECS = 5
) (
    input logic              CLOCK_50,
    input logic              reset,
    countdown_timer_if.slave intf
);
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PreMax = PW'(CLK_HZ - 1);

    if (STEP * 15 > 255) begin : g_step_check
        $error("countdown_timer: 15*STEP must not exceed 255");
    end
    if (ALARM_SECS == 0 || CLK_HZ == 0) begin : g_param_check
        $error("countdown_timer: ALARM_SECS and CLK_HZ must be non-zero");
    end

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e        state_q, state_d;
    logic [2:0]    sw_sync_q;
    logic [1:0]    clr_sync_q;
    logic [7:0]    value_q, value_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          sw_rise, sw_fall, clr, tick;
    logic          do_load, alarm_busy;
    logic [7:0]    load_val;

    assign sw_rise  = sw_sync_q[1] & ~sw_sync_q[2];
    assign sw_fall  = ~sw_sync_q[1] & sw_sync_q[2];
    assign clr      = clr_sync_q[1];
    assign tick     = (presc_q == PreMax);
    assign load_val = 8'(intf.Timer * STEP);

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        do_load = 1'b0;
        if (clr) begin
            state_d = StIdle;
            value_d = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                StIdle: do_load = sw_rise;
                StRun: begin
                    if (tick) begin
                        presc_d = '0;
                        // Expiry outranks a coincident pause request.
                        if (value_q <= 8'd1) begin
                            value_d = '0;
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            value_d = value_q - 8'd1;
                            if (sw_fall) state_d = StPause;
                        end
                    end else if (sw_fall) begin
                        state_d = StPause;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                StPause: if (sw_rise) state_d = StRun;
                StDone: begin
                    if (sw_rise) begin
                        do_load = 1'b1;
                    end else if (alarm_busy) begin
                        presc_d = tick ? '0 : presc_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (do_load) begin
                value_d = load_val;
                presc_d = '0;
                if (load_val == 8'd0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
        end
        running_d = (state_d == StRun);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StIdle;
            sw_sync_q  <= '0;
            clr_sync_q <= '0;
            value_q    <= '0;
            presc_q    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sw_sync_q  <= {sw_sync_q[1:0], intf.TimerSwitch};
            clr_sync_q <= {clr_sync_q[0], intf.TimerClear};
            value_q    <= value_d;
            presc_q    <= presc_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

`ifdef COUNTDOWN_TIMER_ALARM_EN
    localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;

    logic          alarm_q, alarm_d;
    logic [AW-1:0] secs_q, secs_d;

    assign alarm_busy = alarm_q;

    // Seconds remain counted on the shared prescaler while lingering in DONE.
    always_comb begin
        alarm_d = alarm_q;
        secs_d  = secs_q;
        if (done_d) begin
            alarm_d = 1'b1;
            secs_d  = AW'(ALARM_SECS);
        end else if (clr || (state_q == StDone && sw_rise)) begin
            alarm_d = 1'b0;
            secs_d  = '0;
        end else if (alarm_q && state_q == StDone && tick) begin
            if (secs_q <= AW'(1)) begin
                alarm_d = 1'b0;
                secs_d  = '0;
            end else begin
                secs_d = secs_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            alarm_q <= 1'b0;
            secs_q  <= '0;
        end else begin
            alarm_q <= alarm_d;
            secs_q  <= secs_d;
        end
    end

    assign intf.TimerAlarm = alarm_q;
`else
    assign alarm_busy      = 1'b0;
    assign intf.TimerAlarm = 1'b0;
`endif

    assign intf.BinTimerOut  = value_q;
    assign intf.TimerRunning = running_q;
    assign intf.TimerDone    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random switch/clear/reset activity, all
// compared each cycle against a cycle-count reference model (two instances, STEP 10 and 17).
module tb_countdown_timer;
    localparam int unsigned ClkHz     = 10;
    localparam int unsigned AlarmSecs = 5;
`ifdef COUNTDOWN_TIMER_ALARM_EN
    localparam int unsigned ExpAlarmCycles = AlarmSecs * ClkHz;
`else
    localparam int unsigned ExpAlarmCycles = 0;
`endif
    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MDone  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] timer;
    logic       sw;
    logic       clr;

    countdown_timer_if tif ();
    countdown_timer_if tif_max ();

    assign tif.Timer           = timer;
    assign tif.TimerSwitch     = sw;
    assign tif.TimerClear      = clr;
    assign tif_max.Timer       = timer;
    assign tif_max.TimerSwitch = sw;
    assign tif_max.TimerClear  = clr;

    countdown_timer #(
        .CLK_HZ    (ClkHz),
        .STEP      (10),
        .ALARM_SECS(AlarmSecs)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .intf    (tif)
    );

    countdown_timer #(
        .CLK_HZ    (ClkHz),
        .STEP      (17),
        .ALARM_SECS(AlarmSecs)
    ) dut_max (
        .CLOCK_50(clk),
        .reset   (rst),
        .intf    (tif_max)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Input levels as seen at the most recent edges; index 0 is the newest.
    bit sw_hist [4];
    bit clr_hist[3];
    int m_mode  [2];
    int m_val   [2];
    int m_frac  [2];
    int m_alarm [2];
    bit m_done  [2];

    task automatic check(string tag, int unsigned got, int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int step_of(int k);
        return (k == 0) ? 10 : 17;
    endfunction

    task automatic model_expire(int k);
        m_mode[k]  = MDone;
        m_val[k]   = 0;
        m_done[k]  = 1'b1;
        m_alarm[k] = AlarmSecs * ClkHz;
    endtask

    task automatic model_load(int k);
        m_val[k]   = int'(timer) * step_of(k);
        m_frac[k]  = 0;
        m_alarm[k] = 0;
        if (m_val[k] == 0) model_expire(k);
        else m_mode[k] = MRun;
    endtask

    // One rising edge of the reference: inputs take 2 edges to arrive, edge detect needs a third.
    task automatic model_edge();
        bit rise, fall, clr_eff;
        if (rst) begin
            for (int i = 0; i < 4; i++) sw_hist[i] = 1'b0;
            for (int i = 0; i < 3; i++) clr_hist[i] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = MIdle; m_val[k] = 0; m_frac[k] = 0; m_alarm[k] = 0; m_done[k] = 1'b0;
            end
            return;
        end
        for (int i = 3; i > 0; i--) sw_hist[i] = sw_hist[i-1];
        sw_hist[0] = sw;
        for (int i = 2; i > 0; i--) clr_hist[i] = clr_hist[i-1];
        clr_hist[0] = clr;
        rise    = sw_hist[2] && !sw_hist[3];
        fall    = !sw_hist[2] && sw_hist[3];
        clr_eff = clr_hist[2];
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (clr_eff) begin
                m_mode[k] = MIdle; m_val[k] = 0; m_frac[k] = 0; m_alarm[k] = 0;
            end else begin
                case (m_mode[k])
                    MIdle: if (rise) model_load(k);
                    MRun: begin
                        if (m_frac[k] + 1 == ClkHz) begin
                            m_frac[k] = 0;
                            m_val[k]  = m_val[k] - 1;
                            if (m_val[k] == 0) model_expire(k);
                            else if (fall) m_mode[k] = MPause;
                        end else if (fall) begin
                            m_mode[k] = MPause;
                        end else begin
                            m_frac[k] = m_frac[k] + 1;
                        end
                    end
                    MPause: if (rise) m_mode[k] = MRun;
                    default: begin
                        if (rise) model_load(k);
                        else if (m_alarm[k] > 0) m_alarm[k] = m_alarm[k] - 1;
                    end
                endcase
            end
        end
    endtask

    task automatic compare_all();
        int unsigned gv, gr, gd, ga, ea;
        for (int k = 0; k < 2; k++) begin
            gv = (k == 0) ? tif.BinTimerOut  : tif_max.BinTimerOut;
            gr = (k == 0) ? tif.TimerRunning : tif_max.TimerRunning;
            gd = (k == 0) ? tif.TimerDone    : tif_max.TimerDone;
            ga = (k == 0) ? tif.TimerAlarm   : tif_max.TimerAlarm;
`ifdef COUNTDOWN_TIMER_ALARM_EN
            ea = (m_alarm[k] > 0) ? 1 : 0;
`else
            ea = 0;
`endif
            check($sformatf("c%0d.d%0d.value", cycle, k), gv, m_val[k]);
            check($sformatf("c%0d.d%0d.running", cycle, k), gr, (m_mode[k] == MRun) ? 1 : 0);
            check($sformatf("c%0d.d%0d.done", cycle, k), gd, m_done[k]);
            check($sformatf("c%0d.d%0d.alarm", cycle, k), ga, ea);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            cycle++;
            compare_all();
        end
    endtask

    task automatic go_idle();
        clr = 1'b1; sw = 1'b0;
        step(4);
        clr = 1'b0;
        step(2);
    endtask

    int unsigned alarm_cycles;

    initial begin
        rst = 1'b1; sw = 1'b0; clr = 1'b0; timer = 4'd0;
        step(3);
        check("reset.value", tif.BinTimerOut, 0);
        check("reset.running", tif.TimerRunning, 0);
        check("reset.done", tif.TimerDone, 0);
        check("reset.alarm", tif.TimerAlarm, 0);
        rst = 1'b0;
        step(2);

        // Load 3*STEP, first decrement exactly CLK_HZ cycles after the load edge.
        timer = 4'd3; sw = 1'b1;
        step(3);
        check("load.value", tif.BinTimerOut, 30);
        check("load.running", tif.TimerRunning, 1);
        check("load.value_max", tif_max.BinTimerOut, 51);
        step(9);
        check("load.hold", tif.BinTimerOut, 30);
        step(1);
        check("load.first_dec", tif.BinTimerOut, 29);

        // Pause four prescaler counts into a second, then resume from the held count.
        go_idle();
        timer = 4'd2; sw = 1'b1;
        step(3);
        check("pause.loaded", tif.BinTimerOut, 20);
        step(2);
        sw = 1'b0;
        step(3);
        check("pause.running", tif.TimerRunning, 0);
        step(50);
        check("pause.frozen", tif.BinTimerOut, 20);
        sw = 1'b1;
        step(3);
        check("resume.running", tif.TimerRunning, 1);
        step(5);
        check("resume.hold", tif.BinTimerOut, 20);
        step(1);
        check("resume.dec", tif.BinTimerOut, 19);

        // Full expiry of a 10 s preset, then the alarm window.
        go_idle();
        timer = 4'd1; sw = 1'b1;
        step(3);
        check("expiry.loaded", tif.BinTimerOut, 10);
        step(99);
        check("expiry.last", tif.BinTimerOut, 1);
        check("expiry.no_early_done", tif.TimerDone, 0);
        step(1);
        check("expiry.value", tif.BinTimerOut, 0);
        check("expiry.done", tif.TimerDone, 1);
        alarm_cycles = tif.TimerAlarm;
        step(1);
        check("expiry.done_one_cycle", tif.TimerDone, 0);
        alarm_cycles += tif.TimerAlarm;
        for (int i = 0; i < 58; i++) begin
            step(1);
            alarm_cycles += tif.TimerAlarm;
        end
        check("expiry.alarm_cycles", alarm_cycles, ExpAlarmCycles);

        // Zero preset reloaded from DONE: immediate expiry pulse.
        sw = 1'b0;
        step(5);
        timer = 4'd0; sw = 1'b1;
        step(3);
        check("zero.done", tif.TimerDone, 1);
        check("zero.value", tif.BinTimerOut, 0);
        check("zero.running", tif.TimerRunning, 0);
        step(1);
        check("zero.done_low", tif.TimerDone, 0);

        // Clear lands on the very tick that would have expired the count.
        go_idle();
        timer = 4'd1; sw = 1'b1;
        step(3);
        step(97);
        clr = 1'b1;
        step(3);
        check("clear.value", tif.BinTimerOut, 0);
        check("clear.running", tif.TimerRunning, 0);
        check("clear.no_done", tif.TimerDone, 0);
        check("clear.alarm", tif.TimerAlarm, 0);
        step(20);
        check("clear.stays_idle", tif.BinTimerOut, 0);
        clr = 1'b0; sw = 1'b0;
        step(4);

        // Largest preset with STEP=17.
        timer = 4'd15; sw = 1'b1;
        step(3);
        check("max.loaded", tif_max.BinTimerOut, 255);
        check("max.loaded_d0", tif.BinTimerOut, 150);
        step(10);
        check("max.first_dec", tif_max.BinTimerOut, 254);

        // Reset mid-count.
        rst = 1'b1;
        step(1);
        check("midrst.value", tif_max.BinTimerOut, 0);
        check("midrst.running", tif_max.TimerRunning, 0);
        rst = 1'b0; sw = 1'b0;
        step(3);

        // Random activity against the reference model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 29) == 0) sw = ~sw;
            if ($urandom_range(0, 4) == 0) timer = 4'($urandom_range(0, 15));
            if (clr) clr = ($urandom_range(0, 2) != 0);
            else clr = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 1499) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
